bus_manager_mc: RTL and testbench

- Multi-channel successor to the single-requester expansion-port bus manager.
- Owns PHI2-relative DMA timing: address/data buffer enables and directions, R/W drive and the DMA line.
- Arbitrates NUM_CH DMA requesters round-robin, with a configurable setup delay, BA stop threshold and a configurable write-trigger address.
- Sits between the C64 expansion-port pads and internal DMA engines (REU, fill, copy channels). ROM/IO read muxing stays in the existing front end.

---
 rtl/bus_manager_mc.sv | 203 ++++++++++++++++++++
 tb/tb_bus_manager_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_manager_mc.sv
// Multi-channel expansion-port DMA bus manager: PHI2-relative buffer
// control, round-robin arbitration of toggle-handshake DMA channels.
// Ports: clk/reset; phi; a_d/a_q/a_oe/as_dir/as_en_n address path;
// d_d/d_q/d_oe/ds_dir/ds_en_n data path; ba, rw_in, rw_out, dma;
// ch_a/ch_d/ch_rw/ch_req/ch_ack/ch_q channel side; grant_ch/grant_vld;
// trig_w_strobe pulses on a CPU write to TRIG_ADDR.
module bus_manager_mc #(
  parameter int NUM_CH = 2,
  parameter int AW = 16,
  parameter int SETUP_DLY = 15,
  parameter int BA_STOP = 3,
  parameter logic [AW-1:0] TRIG_ADDR = AW'(16'hFF00),
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 phi,
  input  logic [AW-1:0]        a_d,
  output logic [AW-1:0]        a_q,
  output logic                 a_oe,
  output logic                 as_dir,
  output logic                 as_en_n,
  input  logic [7:0]           d_d,
  output logic [7:0]           d_q,
  output logic                 d_oe,
  output logic                 ds_dir,
  output logic                 ds_en_n,
  input  logic                 ba,
  input  logic                 rw_in,
  output logic                 rw_out,
  output logic                 dma,
  input  logic [NUM_CH*AW-1:0] ch_a,
  input  logic [NUM_CH*8-1:0]  ch_d,
  input  logic [NUM_CH-1:0]    ch_rw,
  input  logic [NUM_CH-1:0]    ch_req,
  output logic [NUM_CH-1:0]    ch_ack,
  output logic [7:0]           ch_q,
  output logic [GW-1:0]        grant_ch,
  output logic                 grant_vld,
  output logic                 trig_w_strobe
);

  typedef enum logic [3:0] {
    IDLE, W0, P0_0, P0_1, P0_2, DLY, ARB,
    W1, P1_0, P1_1, P1_2, P1_3, P1_4, HOLD
  } state_t;

  state_t            state;
  logic [7:0]        dly;
  logic [2:0]        ba_cnt;
  logic [1:0]        rw_log;
  logic              rw_mode;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     sel;
  logic [GW-1:0]     nxt;
  logic              sel_ok;
  logic              can_req;
  logic [NUM_CH-1:0] pend;
  logic [AW-1:0]     g_a;
  logic [7:0]        g_d;
  logic              g_rw;

  assign pend = ch_req ^ ch_ack;

  // CPU halted by BA, or a read directly after a CPU write
  assign can_req = (ba_cnt == 3'(BA_STOP)) || (rw_log == 2'b01);

  assign nxt = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;

  assign g_a  = ch_a[int'(grant_ch)*AW +: AW];
  assign g_d  = ch_d[int'(grant_ch)*8 +: 8];
  assign g_rw = ch_rw[grant_ch];

  // first pending channel at or after ptr; lowest offset wins
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend[(int'(ptr) + k) % NUM_CH]) begin
        sel    = GW'((int'(ptr) + k) % NUM_CH);
        sel_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dly           <= '0;
      ba_cnt        <= '0;
      rw_log        <= 2'b11;
      rw_mode       <= 1'b1;
      ptr           <= '0;
      a_q           <= '0;
      d_q           <= '0;
      a_oe          <= 1'b0;
      d_oe          <= 1'b0;
      as_dir        <= 1'b0;
      ds_dir        <= 1'b0;
      as_en_n       <= 1'b1;
      ds_en_n       <= 1'b1;
      rw_out        <= 1'b0;
      dma           <= 1'b0;
      ch_ack        <= '0;
      ch_q          <= '0;
      grant_ch      <= '0;
      grant_vld     <= 1'b0;
      trig_w_strobe <= 1'b0;
    end else begin
      trig_w_strobe <= 1'b0;
      unique case (state)
        IDLE: if (phi) state <= W0;
        W0: if (!phi) state <= P0_0;
        P0_0: begin
          if (!rw_in && a_d == TRIG_ADDR)
            trig_w_strobe <= 1'b1;
          // own DMA cycles count as reads
          rw_log <= {rw_log[0], rw_in | dma};
          state  <= P0_1;
        end
        P0_1: begin
          ds_en_n <= 1'b1;
          as_en_n <= 1'b1;
          a_oe    <= 1'b0;
          d_oe    <= 1'b0;
          state   <= P0_2;
        end
        P0_2: begin
          as_dir <= 1'b0;
          ds_dir <= 1'b0;
          rw_out <= 1'b0;
          dly    <= 8'(SETUP_DLY);
          state  <= DLY;
        end
        DLY: begin
          if (dly == '0) state <= ARB;
          else dly <= dly - 8'd1;
        end
        ARB: begin
          if (!sel_ok) begin
            dma       <= 1'b0;
            grant_vld <= 1'b0;
          end else if (dma || can_req) begin
            dma       <= 1'b1;
            grant_ch  <= sel;
            grant_vld <= 1'b1;
          end else begin
            grant_vld <= 1'b0;
          end
          state <= W1;
        end
        W1: begin
          as_en_n <= 1'b0;
          if (phi) state <= P1_0;
        end
        P1_0: begin
          if (ba) ba_cnt <= '0;
          else if (ba_cnt != 3'(BA_STOP))
            ba_cnt <= ba_cnt + 3'd1;
          if (dma && grant_vld && ba) begin
            as_en_n <= 1'b1;
            state   <= P1_1;
          end else begin
            state <= W0;
          end
        end
        P1_1: begin
          a_q     <= g_a;
          d_q     <= g_d;
          rw_mode <= g_rw;
          as_dir  <= 1'b1;
          ds_dir  <= g_rw;
          state   <= P1_2;
        end
        P1_2: begin
          as_en_n <= 1'b0;
          a_oe    <= 1'b1;
          rw_out  <= rw_mode;
          state   <= P1_3;
        end
        P1_3: begin
          d_oe  <= ~rw_mode;
          state <= P1_4;
        end
        P1_4: begin
          ds_en_n <= 1'b0;
          state   <= HOLD;
        end
        HOLD: begin
          if (phi) begin
            ch_q <= d_d;
          end else begin
            ch_ack[grant_ch] <= ~ch_ack[grant_ch];
            ptr   <= nxt;
            state <= P0_0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_manager_mc.sv
// Bench for bus_manager_mc: per-bus-cycle reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_bus_manager_mc;

  localparam int N = 4;
  localparam int AW = 16;
  localparam int SD = 4;
  localparam int BS = 3;
  localparam logic [15:0] TRIG = 16'hFF00;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            phi = 1'b0;
  logic [AW-1:0]   a_d = '0;
  logic [AW-1:0]   a_q;
  logic            a_oe, as_dir, as_en_n;
  logic [7:0]      d_d = '0;
  logic [7:0]      d_q;
  logic            d_oe, ds_dir, ds_en_n;
  logic            ba = 1'b1;
  logic            rw_in = 1'b1;
  logic            rw_out, dma;
  logic [N*AW-1:0] ch_a = '0;
  logic [N*8-1:0]  ch_d = '0;
  logic [N-1:0]    ch_rw = '0;
  logic [N-1:0]    ch_req = '0;
  logic [N-1:0]    ch_ack;
  logic [7:0]      ch_q;
  logic [1:0]      grant_ch;
  logic            grant_vld, trig_w_strobe;

  bus_manager_mc #(
    .NUM_CH(N), .AW(AW), .SETUP_DLY(SD),
    .BA_STOP(BS), .TRIG_ADDR(TRIG)
  ) dut (
    .clk(clk), .reset(reset), .phi(phi),
    .a_d(a_d), .a_q(a_q), .a_oe(a_oe),
    .as_dir(as_dir), .as_en_n(as_en_n),
    .d_d(d_d), .d_q(d_q), .d_oe(d_oe),
    .ds_dir(ds_dir), .ds_en_n(ds_en_n),
    .ba(ba), .rw_in(rw_in), .rw_out(rw_out),
    .dma(dma), .ch_a(ch_a), .ch_d(ch_d),
    .ch_rw(ch_rw), .ch_req(ch_req),
    .ch_ack(ch_ack), .ch_q(ch_q),
    .grant_ch(grant_ch), .grant_vld(grant_vld),
    .trig_w_strobe(trig_w_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_ptr, m_g, m_bacnt;
  logic [N-1:0] m_ack;
  logic        m_dma, m_gv;
  logic [1:0]  m_log;
  logic [7:0]  m_q;
  logic        prev_rw;
  logic [15:0] prev_ad;
  int          trig_cnt, last_trig;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (trig_w_strobe === 1'b1) trig_cnt++;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    phi    = 1'b0;
    ch_req = '0;
    rw_in  = 1'b1;
    a_d    = '0;
    ba     = 1'b1;
    d_d    = '0;
    repeat (3) tick();
    chk("rst_ctl",
        {as_en_n, ds_en_n, a_oe, d_oe, as_dir, ds_dir,
         rw_out, dma, grant_vld, trig_w_strobe},
        10'b11_0000_0000);
    chk("rst_ack", ch_ack, 0);
    chk("rst_q", ch_q, 0);
    chk("rst_gch", grant_ch, 0);
    reset   = 1'b0;
    m_ptr   = 0;
    m_g     = 0;
    m_bacnt = 0;
    m_ack   = '0;
    m_dma   = 1'b0;
    m_gv    = 1'b0;
    m_log   = 2'b11;
    m_q     = '0;
    prev_rw = 1'b1;
    prev_ad = '0;
    phi = 1'b1;
    repeat (12) tick();
  endtask

  // One full PHI2 period: phase 0 (ticks 1..12) then phase 1 (13..24).
  task automatic cycle(input logic [N-1:0] tog,
                       input logic b,
                       input logic rw,
                       input logic [15:0] ad,
                       input logic [7:0] dd,
                       input bit rst_hold);
    logic [N-1:0] pend;
    logic can, xfer, r;
    int exp_trig;
    phi = 1'b0;
    exp_trig = (!prev_rw && prev_ad == TRIG) ? 1 : 0;
    m_log = {m_log[0], prev_rw | m_dma};
    trig_cnt = 0;
    repeat (4) tick();
    chk("ack", ch_ack, m_ack);
    chk("ch_q", ch_q, m_q);
    ba = b;
    rw_in = rw;
    a_d = ad;
    d_d = dd;
    ch_req = ch_req ^ tog;
    pend = ch_req ^ m_ack;
    can = (m_bacnt == BS) || (m_log == 2'b01);
    if (pend == '0) begin
      m_dma = 1'b0;
      m_gv = 1'b0;
    end else if (m_dma || can) begin
      m_dma = 1'b1;
      m_gv = 1'b1;
      for (int k = N - 1; k >= 0; k--)
        if (pend[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
    end else begin
      m_gv = 1'b0;
    end
    repeat (8) tick();
    phi = 1'b1;
    repeat (10) tick();
    xfer = m_dma && m_gv && b;
    m_bacnt = b ? 0 : ((m_bacnt < BS) ? m_bacnt + 1 : BS);
    r = ch_rw[m_g];
    if (xfer)
      chk("p1_ctl",
          {dma, grant_vld, a_oe, as_en_n, ds_en_n,
           as_dir, ds_dir, rw_out, d_oe},
          {m_dma, m_gv, 1'b1, 1'b0, 1'b0, 1'b1, r, r, ~r});
    else
      chk("p1_ctl",
          {dma, grant_vld, a_oe, as_en_n, ds_en_n,
           as_dir, ds_dir, rw_out, d_oe},
          {m_dma, m_gv, 7'b0010000});
    if (m_gv) chk("gch", grant_ch, m_g);
    if (xfer) begin
      chk("a_q", a_q, ch_a[m_g*AW +: AW]);
      chk("d_q", d_q, ch_d[m_g*8 +: 8]);
    end
    if (rst_hold) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rh_dma", dma, 0);
      chk("rh_ack", ch_ack, m_ack);
      chk("rh_aoe", a_oe, 0);
      chk("rh_dsen", ds_en_n, 1);
      return;
    end
    repeat (2) tick();
    if (xfer) begin
      m_ack[m_g] = ~m_ack[m_g];
      m_ptr = (m_g + 1) % N;
      m_q = dd;
    end
    chk("trig", trig_cnt, exp_trig);
    last_trig = trig_cnt;
    prev_rw = rw;
    prev_ad = ad;
  endtask

  initial begin
    do_reset();
    ch_a  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    ch_d  = {8'h33, 8'h22, 8'h11, 8'h00};
    ch_rw = 4'b0000;
    // BA-stop: two low samples are not enough, three are
    cycle(4'b1101, 1'b0, 1'b1, 16'h0, 8'h0, 0);
    cycle(4'b0000, 1'b0, 1'b1, 16'h0, 8'h0, 0);
    chk("ba2_nodma", dma, 0);
    cycle(4'b0000, 1'b0, 1'b1, 16'h0, 8'h0, 0);
    chk("ba3_pre", dma, 0);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("g0_dma", dma, 1);
    chk("g0", grant_ch, 0);
    chk("g0_aq", a_q, 16'hA000);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("g2", grant_ch, 2);
    chk("g2_dma", dma, 1);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("g3", grant_ch, 3);
    chk("g3_dma", dma, 1);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("burst_end", dma, 0);
    chk("burst_ack", ch_ack, 4'b1101);
    // trigger strobe and read-after-write read channel
    ch_rw = 4'b0010;
    cycle(4'b0000, 1'b1, 1'b0, 16'hFF00, 8'h0, 0);
    cycle(4'b0000, 1'b1, 1'b1, 16'hFF00, 8'h0, 0);
    chk("trig_hit", last_trig, 1);
    cycle(4'b0010, 1'b1, 1'b0, 16'hFF01, 8'hA5, 0);
    chk("trig_rw1", last_trig, 0);
    chk("rd_gch", grant_ch, 1);
    chk("rd_rw", rw_out, 1);
    chk("rd_doe", d_oe, 0);
    cycle(4'b0000, 1'b1, 1'b0, 16'h1000, 8'h0, 0);
    chk("trig_ff01", last_trig, 0);
    chk("rd_q", ch_q, 8'hA5);
    chk("rd_ack", ch_ack, 4'b1111);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    ch_a[15:0] = 16'hD020;
    ch_d[7:0]  = 8'h05;
    ch_rw[0]   = 1'b0;
    cycle(4'b0001, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("wr_aq", a_q, 16'hD020);
    chk("wr_dq", d_q, 8'h05);
    chk("wr_rw", rw_out, 0);
    chk("wr_doe", d_oe, 1);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    chk("wr_ack", ch_ack, 4'b1110);
    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [N-1:0] tg;
      logic [15:0] ad;
      ch_a  = {$urandom, $urandom};
      ch_d  = $urandom;
      ch_rw = 4'($urandom);
      tg = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0;
      ad = ($urandom % 4 == 0) ? TRIG : 16'($urandom);
      cycle(tg, 1'($urandom), 1'($urandom), ad,
            8'($urandom), 0);
    end
    // reset in the middle of a granted cycle
    do_reset();
    cycle(4'b0000, 1'b1, 1'b0, 16'h0, 8'h0, 0);
    cycle(4'b0000, 1'b1, 1'b1, 16'h0, 8'h0, 0);
    cycle(4'b0010, 1'b1, 1'b1, 16'h0, 8'h0, 1);
    chk("rh_ack0", ch_ack, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
